clk_div_monitor: RTL and testbench

Receiver-side checker for the divided clocks our dividers produce. It samples a slow, asynchronous clock on the fast `clk` and synchronises it. It measures the slow clock's period and high time in `clk` cycles, and declares lock when consecutive periods match the expected division ratio. It sits beside a divider instance or at a board input and feeds status and CSR logic.

---
 rtl/clk_mon_pkg.sv | 15 +
 rtl/sync_edge.sv | 38 +++
 rtl/clk_div_monitor.sv | 168 ++++++++++++++++
 tb/tb_clk_div_monitor.sv | 236 +++++++++++++++++++++++
 4 files changed

// File: rtl/clk_mon_pkg.sv
// Shared types and default parameters for the divided-clock monitor.
package clk_mon_pkg;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      MEAS   = 2'd1,
      LOCKED = 2'd2
   } mon_state_t;

   localparam int unsigned CNT_W_DEF      = 16;
   localparam int unsigned EXP_PERIOD_DEF = 64;
   localparam int unsigned TOL_DEF        = 1;
   localparam int unsigned LOCK_COUNT_DEF = 4;

endpackage

// File: rtl/sync_edge.sv
// Two-flop synchroniser for an asynchronous input plus rise/fall pulse decode.
module sync_edge (
   input  logic clk,
   input  logic rst_n,
   input  logic d,
   output logic level,
   output logic rise,
   output logic fall
);

   logic sync1_q, sync2_q, prev_q;
   logic sync1_d, sync2_d, prev_d;

   // Shift the input through the synchroniser and keep the previous level.
   always_comb begin
      sync1_d = d;
      sync2_d = sync1_q;
      prev_d  = sync2_q;
   end

   // Synchroniser and previous-value flops.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sync1_q <= 1'b0;
         sync2_q <= 1'b0;
         prev_q  <= 1'b0;
      end else begin
         sync1_q <= sync1_d;
         sync2_q <= sync2_d;
         prev_q  <= prev_d;
      end
   end

   assign level = sync2_q;
   assign rise  = sync2_q & ~prev_q;
   assign fall  = ~sync2_q & prev_q;

endmodule

// File: rtl/clk_div_monitor.sv
// Measures period/high time of a slow asynchronous clock and tracks lock to
// the expected division ratio.
module clk_div_monitor
   import clk_mon_pkg::*;
#(
   parameter int unsigned CNT_W      = CNT_W_DEF,
   parameter int unsigned EXP_PERIOD = EXP_PERIOD_DEF,
   parameter int unsigned TOL        = TOL_DEF,
   parameter int unsigned LOCK_COUNT = LOCK_COUNT_DEF
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             sig_in,
   output logic [CNT_W-1:0] period,
   output logic [CNT_W-1:0] high_time,
   output logic             period_valid,
   output logic             locked,
   output logic             err_pulse,
   output logic             timeout
);

   localparam int unsigned     MCNT_W   = $clog2(LOCK_COUNT + 1);
   localparam int unsigned     LO_BOUND = (EXP_PERIOD > TOL) ? (EXP_PERIOD - TOL) : 0;
   localparam int unsigned     HI_BOUND = EXP_PERIOD + TOL;
   localparam logic [CNT_W-1:0] CNT_MAX = '1;

   logic level, rise, fall;

   logic [CNT_W-1:0]  pcnt_q, pcnt_d;
   logic [CNT_W-1:0]  hcnt_q, hcnt_d;
   logic [CNT_W-1:0]  high_hold_q, high_hold_d;
   logic [CNT_W-1:0]  period_q, period_d;
   logic [CNT_W-1:0]  high_time_q, high_time_d;
   logic [MCNT_W-1:0] mcnt_q, mcnt_d;
   mon_state_t        state_q, state_d;
   logic              period_valid_q, period_valid_d;
   logic              locked_q, locked_d;
   logic              err_pulse_q, err_pulse_d;
   logic              timeout_q, timeout_d;
   logic              in_tol_c;
   logic              sat_c;

   sync_edge u_sync_edge (
      .clk   (clk),
      .rst_n (rst_n),
      .d     (sig_in),
      .level (level),
      .rise  (rise),
      .fall  (fall)
   );

   // Bounds are widened to 32 bits so a lower bound clamped at 0 cannot underflow.
   assign in_tol_c = (32'(pcnt_q) >= LO_BOUND) && (32'(pcnt_q) <= HI_BOUND);
   assign sat_c    = (pcnt_q == CNT_MAX);

   // Period and high-phase counters; both saturate instead of wrapping.
   always_comb begin
      pcnt_d      = pcnt_q;
      hcnt_d      = hcnt_q;
      high_hold_d = high_hold_q;
      if (rise) begin
         pcnt_d = CNT_W'(1);
      end else if (!sat_c) begin
         pcnt_d = pcnt_q + CNT_W'(1);
      end
      if (rise) begin
         hcnt_d = CNT_W'(1);
      end else if (level && (hcnt_q != CNT_MAX)) begin
         hcnt_d = hcnt_q + CNT_W'(1);
      end
      if (fall) begin
         high_hold_d = hcnt_q;
      end
   end

   // Lock FSM and status outputs; a rise always beats counter saturation.
   always_comb begin
      state_d        = state_q;
      mcnt_d         = mcnt_q;
      period_d       = period_q;
      high_time_d    = high_time_q;
      period_valid_d = 1'b0;
      err_pulse_d    = 1'b0;
      locked_d       = locked_q;
      timeout_d      = timeout_q;
      if (rise) begin
         timeout_d = 1'b0;
         case (state_q)
            IDLE: begin
               state_d  = MEAS;
               mcnt_d   = '0;
               locked_d = 1'b0;
            end
            MEAS, LOCKED: begin
               period_d       = pcnt_q;
               high_time_d    = high_hold_q;
               period_valid_d = 1'b1;
               if (!in_tol_c) begin
                  err_pulse_d = 1'b1;
                  mcnt_d      = '0;
                  state_d     = MEAS;
                  locked_d    = 1'b0;
               end else if (state_q == MEAS) begin
                  if ((mcnt_q + MCNT_W'(1)) == MCNT_W'(LOCK_COUNT)) begin
                     state_d  = LOCKED;
                     locked_d = 1'b1;
                     mcnt_d   = MCNT_W'(LOCK_COUNT);
                  end else begin
                     mcnt_d = mcnt_q + MCNT_W'(1);
                  end
               end
            end
            default: begin
               state_d = IDLE;
            end
         endcase
      end else if (sat_c) begin
         timeout_d = 1'b1;
         locked_d  = 1'b0;
         state_d   = IDLE;
         mcnt_d    = '0;
      end
   end

   // FSM state register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
         mcnt_q  <= '0;
      end else begin
         state_q <= state_d;
         mcnt_q  <= mcnt_d;
      end
   end

   // Counter and output registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         pcnt_q         <= '0;
         hcnt_q         <= '0;
         high_hold_q    <= '0;
         period_q       <= '0;
         high_time_q    <= '0;
         period_valid_q <= 1'b0;
         locked_q       <= 1'b0;
         err_pulse_q    <= 1'b0;
         timeout_q      <= 1'b0;
      end else begin
         pcnt_q         <= pcnt_d;
         hcnt_q         <= hcnt_d;
         high_hold_q    <= high_hold_d;
         period_q       <= period_d;
         high_time_q    <= high_time_d;
         period_valid_q <= period_valid_d;
         locked_q       <= locked_d;
         err_pulse_q    <= err_pulse_d;
         timeout_q      <= timeout_d;
      end
   end

   assign period       = period_q;
   assign high_time    = high_time_q;
   assign period_valid = period_valid_q;
   assign locked       = locked_q;
   assign err_pulse    = err_pulse_q;
   assign timeout      = timeout_q;

endmodule

// File: tb/tb_clk_div_monitor.sv
// Bench for clk_div_monitor: table of slow-clock cycles with a scoreboard of
// expected measurements, plus timeout, saturation and reset sequences.
module tb_clk_div_monitor;

   localparam int unsigned CW = 8;

   logic          clk;
   logic          rst_n;
   logic          sig_in;
   logic [CW-1:0] period;
   logic [CW-1:0] high_time;
   logic          period_valid;
   logic          locked;
   logic          err_pulse;
   logic          timeout;

   clk_div_monitor #(
      .CNT_W      (CW),
      .EXP_PERIOD (64),
      .TOL        (1),
      .LOCK_COUNT (4)
   ) dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .sig_in       (sig_in),
      .period       (period),
      .high_time    (high_time),
      .period_valid (period_valid),
      .locked       (locked),
      .err_pulse    (err_pulse),
      .timeout      (timeout)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      int hi;
      int lo;
      int e_period;
      int e_high;
      int e_err;
      int e_locked;
   } vec_t;

   typedef struct {
      int period;
      int high;
      int err;
      int locked;
   } exp_t;

   exp_t exp_q[$];
   vec_t vt [0:22];
   int   total = 0;
   int   bad   = 0;
   int   n_valid = 0;
   exp_t mon_e;

   task automatic chk(input string name, input int act, input int req);
      total++;
      if (act != req) begin
         bad++;
         $display("FAIL %s actual=%0d required=%0d at %0t", name, act, req, $time);
      end
   endtask

   function automatic vec_t mk(input int h, input int l, input int err, input int lk);
      vec_t v;
      v.hi       = h;
      v.lo       = l;
      v.e_period = h + l;
      v.e_high   = h;
      v.e_err    = err;
      v.e_locked = lk;
      return v;
   endfunction

   // One slow-clock cycle: its measurement is reported at the following rise.
   task automatic drive_row(input int h, input int l, input int p_e, input int h_e,
                            input int err_e, input int lk_e);
      exp_t e;
      e.period = p_e;
      e.high   = h_e;
      e.err    = err_e;
      e.locked = lk_e;
      exp_q.push_back(e);
      sig_in = 1'b1;
      repeat (h) @(negedge clk);
      sig_in = 1'b0;
      repeat (l) @(negedge clk);
   endtask

   // Scoreboard: every period_valid pops one expectation; stray pulses are errors.
   always @(negedge clk) begin
      if (period_valid) begin
         n_valid++;
         if (exp_q.size() == 0) begin
            chk("unexpected_valid", int'(period_valid), 0);
         end else begin
            mon_e = exp_q.pop_front();
            chk("period", int'(period), mon_e.period);
            chk("high_time", int'(high_time), mon_e.high);
            chk("err_pulse", int'(err_pulse), mon_e.err);
            chk("locked", int'(locked), mon_e.locked);
         end
      end else if (err_pulse) begin
         chk("stray_err_pulse", int'(err_pulse), 0);
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog actual=running required=finished");
      $fatal(1, "watchdog expired");
   end

   initial begin
      int base;
      rst_n  = 1'b0;
      sig_in = 1'b0;
      #1;
      chk("rst_period", int'(period), 0);
      chk("rst_high_time", int'(high_time), 0);
      chk("rst_valid", int'(period_valid), 0);
      chk("rst_locked", int'(locked), 0);
      chk("rst_err", int'(err_pulse), 0);
      chk("rst_timeout", int'(timeout), 0);
      repeat (3) @(negedge clk);
      rst_n = 1'b1;
      repeat (4) @(negedge clk);

      // Divide-by-64 lock, tolerance edges, loss of lock, clear of lock count.
      vt[0]  = mk(32, 32, 0, 0);
      vt[1]  = mk(32, 32, 0, 0);
      vt[2]  = mk(32, 32, 0, 0);
      vt[3]  = mk(32, 32, 0, 1);
      vt[4]  = mk(31, 32, 0, 1);
      vt[5]  = mk(33, 32, 0, 1);
      vt[6]  = mk(33, 33, 1, 0);
      vt[7]  = mk(32, 32, 0, 0);
      vt[8]  = mk(30, 33, 0, 0);
      vt[9]  = mk(32, 33, 0, 0);
      vt[10] = mk(32, 32, 0, 1);
      vt[11] = mk(40, 40, 1, 0);
      vt[12] = mk(32, 32, 0, 0);
      vt[13] = mk(32, 32, 0, 0);
      vt[14] = mk(32, 32, 0, 0);
      vt[15] = mk(32, 32, 0, 1);
      vt[16] = mk(33, 33, 1, 0);
      vt[17] = mk(32, 32, 0, 0);
      vt[18] = mk(31, 31, 1, 0);
      vt[19] = mk(32, 32, 0, 0);
      vt[20] = mk(32, 32, 0, 0);
      vt[21] = mk(32, 32, 0, 0);
      vt[22] = mk(33, 32, 0, 1);
      for (int i = 0; i < 23; i++) begin
         drive_row(vt[i].hi, vt[i].lo, vt[i].e_period, vt[i].e_high,
                   vt[i].e_err, vt[i].e_locked);
      end

      // Stuck-low input after one high phase: timeout at 255 cycles past the rise.
      sig_in = 1'b1;
      repeat (32) @(negedge clk);
      sig_in = 1'b0;
      repeat (225) @(negedge clk);
      chk("timeout_early", int'(timeout), 0);
      chk("locked_before_timeout", int'(locked), 1);
      @(negedge clk);
      chk("timeout_set", int'(timeout), 1);
      chk("timeout_locked", int'(locked), 0);
      chk("timeout_hold_period", int'(period), 65);
      chk("timeout_hold_high", int'(high_time), 33);
      repeat (10) @(negedge clk);

      // Re-arm from timeout, then a 255-cycle period whose rise meets saturation.
      base = n_valid;
      exp_q.push_back('{period: 255, high: 32, err: 1, locked: 0});
      sig_in = 1'b1;
      repeat (2) @(negedge clk);
      chk("timeout_before_rearm", int'(timeout), 1);
      @(negedge clk);
      chk("timeout_cleared", int'(timeout), 0);
      chk("rearm_no_valid", n_valid - base, 0);
      repeat (29) @(negedge clk);
      sig_in = 1'b0;
      repeat (223) @(negedge clk);

      // Closing rise of the 255 period starts four good periods to relock.
      drive_row(32, 32, 64, 32, 0, 0);
      chk("sat_no_timeout", int'(timeout), 0);
      drive_row(32, 32, 64, 32, 0, 0);
      drive_row(32, 32, 64, 32, 0, 0);
      drive_row(32, 32, 64, 32, 0, 1);
      sig_in = 1'b1;
      repeat (5) @(negedge clk);
      chk("locked_before_reset", int'(locked), 1);
      repeat (15) @(negedge clk);

      // Asynchronous reset while locked.
      chk("queue_before_reset", exp_q.size(), 0);
      #2;
      rst_n = 1'b0;
      #1;
      chk("mid_rst_period", int'(period), 0);
      chk("mid_rst_high_time", int'(high_time), 0);
      chk("mid_rst_valid", int'(period_valid), 0);
      chk("mid_rst_locked", int'(locked), 0);
      chk("mid_rst_err", int'(err_pulse), 0);
      chk("mid_rst_timeout", int'(timeout), 0);
      sig_in = 1'b0;
      exp_q.delete();
      repeat (3) @(negedge clk);
      rst_n = 1'b1;
      repeat (4) @(negedge clk);

      // First rise after reset only arms; the second reports the period.
      base = n_valid;
      exp_q.push_back('{period: 64, high: 32, err: 0, locked: 0});
      sig_in = 1'b1;
      repeat (5) @(negedge clk);
      chk("post_reset_arm_no_valid", n_valid - base, 0);
      repeat (27) @(negedge clk);
      sig_in = 1'b0;
      repeat (32) @(negedge clk);
      drive_row(30, 34, 64, 30, 0, 0);
      sig_in = 1'b1;
      repeat (6) @(negedge clk);
      chk("post_reset_valids", n_valid - base, 2);
      chk("queue_drained", exp_q.size(), 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
